// File: rtl/fixed_mul_pkg.sv
// Shared constants and types for the fixed-point multiplier arbiter.
// Operands pack A in the low half and B in the high half.
package fixed_mul_pkg;

    localparam int OPER_W = 64;
    localparam int RES_W  = 32;
    localparam int HALF_W = 32;
    localparam int A_LSB  = 0;
    localparam int B_LSB  = HALF_W;

    typedef logic [OPER_W-1:0] oper_t;
    typedef logic [RES_W-1:0]  res_t;

    function automatic int tag_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fixed_mul_arbiter_if.sv
// Requester-side and multiplier-side handshake bundle for the arbiter.
// master = arbiter view, slave = environment view.
interface fixed_mul_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import fixed_mul_pkg::*;

    logic [NUM_REQ-1:0]        reqOperandsReady;
    logic [OPER_W*NUM_REQ-1:0] reqOperandsData;
    logic [NUM_REQ-1:0]        reqOperandsStop;
    logic [NUM_REQ-1:0]        reqResultReady;
    logic [RES_W*NUM_REQ-1:0]  reqResultData;
    logic [NUM_REQ-1:0]        reqResultStop;
    logic                      mulOperandsReady;
    oper_t                     mulOperandsData;
    logic                      mulOperandsStop;
    logic                      mulResultReady;
    res_t                      mulResultData;
    logic                      mulResultStop;

    modport master (
        input  reqOperandsReady, reqOperandsData, reqResultStop,
        input  mulOperandsStop, mulResultReady, mulResultData,
        output reqOperandsStop, reqResultReady, reqResultData,
        output mulOperandsReady, mulOperandsData, mulResultStop
    );

    modport slave (
        output reqOperandsReady, reqOperandsData, reqResultStop,
        output mulOperandsStop, mulResultReady, mulResultData,
        input  reqOperandsStop, reqResultReady, reqResultData,
        input  mulOperandsReady, mulOperandsData, mulResultStop
    );

endinterface

// File: rtl/fixed_mul_tag_fifo.sv
// In-order tag FIFO remembering which requester owns each issued operation.
// Storage is not reset; pointers and count are.
module fixed_mul_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/fixed_mul_arbiter.sv
// Round-robin sharing of one 26d6 multiplier between NUM_REQ clients,
// with a registered issue stage and in-order result routing by tag.
module fixed_mul_arbiter
    import fixed_mul_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int TAG_DEPTH = 4,
    parameter int TAG_W     = 2
) (
    input  logic                clk,
    input  logic                arst_n,
    fixed_mul_arbiter_if.master bus,
    output logic [TAG_W:0]      inFlight,
    output logic                protoError
);

    localparam int CW    = $clog2(TAG_DEPTH) + 1;
    localparam int SUM_W = TAG_W + 1;
    localparam int IW    = TAG_W + 1;

    if (TAG_W != tag_w(NUM_REQ)) begin : g_bad_tag_w
        $error("TAG_W must be ceil(log2(NUM_REQ))");
    end

    logic             issue_vld_q, issue_vld_d;
    oper_t            issue_data_q, issue_data_d;
    logic [TAG_W-1:0] issue_tag_q, issue_tag_d;
    logic [TAG_W-1:0] rr_q, rr_d;
    logic             perr_q, perr_d;
    logic [TAG_W-1:0] gnt_idx, head_tag;
    logic             gnt_vld, can_load, load;
    logic             issue_xfer, res_xfer;
    logic             fifo_empty, fifo_full;
    logic [CW-1:0]    fifo_cnt;
    logic [SUM_W-1:0] sum;

    assign issue_xfer = issue_vld_q & ~bus.mulOperandsStop;

    // The issue slot counts as in flight so the FIFO can never overflow.
    assign can_load = (~issue_vld_q | issue_xfer) & ~fifo_full &
                      ((fifo_cnt + CW'(issue_vld_q)) < CW'(TAG_DEPTH));

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_q} + SUM_W'(k);
            if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
            if (!gnt_vld && bus.reqOperandsReady[sum[TAG_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = sum[TAG_W-1:0];
            end
        end
    end

    assign load = can_load & gnt_vld & arst_n;

    always_comb begin
        bus.reqOperandsStop = '1;
        if (load) bus.reqOperandsStop[gnt_idx] = 1'b0;
    end

    always_comb begin
        issue_vld_d  = issue_vld_q;
        issue_data_d = issue_data_q;
        issue_tag_d  = issue_tag_q;
        rr_d         = rr_q;
        if (load) begin
            issue_vld_d  = 1'b1;
            issue_data_d = bus.reqOperandsData[gnt_idx*OPER_W +: OPER_W];
            issue_tag_d  = gnt_idx;
            rr_d = (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (issue_xfer) begin
            issue_vld_d = 1'b0;
        end
    end

    assign bus.mulOperandsReady = issue_vld_q;
    assign bus.mulOperandsData  = issue_data_q;

    // A result with no owner is still accepted so the multiplier drains.
    always_comb begin
        bus.reqResultReady = '0;
        if (!fifo_empty) bus.reqResultReady[head_tag] = bus.mulResultReady;
    end

    assign bus.mulResultStop = ~fifo_empty & bus.reqResultStop[head_tag];
    assign bus.reqResultData = {NUM_REQ{bus.mulResultData}};
    assign res_xfer = bus.mulResultReady & ~bus.mulResultStop & ~fifo_empty;
    assign perr_d   = perr_q | (bus.mulResultReady & fifo_empty);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            issue_vld_q <= 1'b0;
            rr_q        <= '0;
            perr_q      <= 1'b0;
        end else begin
            issue_vld_q <= issue_vld_d;
            rr_q        <= rr_d;
            perr_q      <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        issue_data_q <= issue_data_d;
        issue_tag_q  <= issue_tag_d;
    end

    fixed_mul_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (TAG_W)
    ) u_tag_fifo (
        .clk     (clk),
        .arst_n  (arst_n),
        .push_i  (issue_xfer),
        .pop_i   (res_xfer),
        .din_i   (issue_tag_q),
        .dout_o  (head_tag),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign inFlight   = IW'(fifo_cnt);
    assign protoError = perr_q;

endmodule

// File: tb/tb_fixed_mul_arbiter.sv
// Bench for fixed_mul_arbiter: queue-based reference model, an emulated
// 26d6 multiplier, per-requester result scoreboard and directed cases.
module tb_fixed_mul_arbiter;

    localparam int NR    = 4;
    localparam int DEPTH = 4;
    localparam int TW    = 2;

    logic          clk;
    logic          arst_n;
    logic [TW:0]   inFlight;
    logic          protoError;

    fixed_mul_arbiter_if #(.NUM_REQ(NR)) bus ();

    fixed_mul_arbiter #(
        .NUM_REQ   (NR),
        .TAG_DEPTH (DEPTH),
        .TAG_W     (TW)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .bus        (bus),
        .inFlight   (inFlight),
        .protoError (protoError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] mq [$];
    logic [31:0] prod [NR][$];

    int          m_tq [$];
    bit          m_iv;
    logic [63:0] m_data;
    int          m_tag;
    int          m_rr;
    bit          m_perr;

    function automatic logic [31:0] fmul(input logic [63:0] op);
        longint p;
        p = longint'($signed(op[31:0])) * longint'($signed(op[63:32]));
        return 32'(p >>> 6);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model and per-cycle comparison, sampled mid-cycle.
    initial begin : compare
        int          g;
        int          h;
        bit          can;
        logic [NR-1:0] e_stop;
        logic [NR-1:0] e_rdy;
        logic        e_mrs;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                m_tq.delete();
                m_iv   = 0;
                m_rr   = 0;
                m_perr = 0;
                for (int i = 0; i < NR; i++) prod[i].delete();
                chk("rst_stop", bus.reqOperandsStop, 4'hF);
                chk("rst_rres", bus.reqResultReady, 4'h0);
                chk("rst_mrdy", bus.mulOperandsReady, 0);
                chk("rst_infl", inFlight, 0);
                chk("rst_perr", protoError, 0);
                continue;
            end
            can = (!m_iv || !bus.mulOperandsStop) &&
                  (m_tq.size() + int'(m_iv) < DEPTH);
            g = -1;
            if (can) begin
                for (int k = 0; k < NR; k++) begin
                    int j;
                    j = (m_rr + k) % NR;
                    if (g < 0 && bus.reqOperandsReady[j]) g = j;
                end
            end
            e_stop = 4'hF;
            if (g >= 0) e_stop[g] = 1'b0;
            e_rdy = '0;
            e_mrs = 1'b0;
            if (m_tq.size() > 0) begin
                h = m_tq[0];
                e_rdy[h] = bus.mulResultReady;
                e_mrs = bus.reqResultStop[h];
            end
            chk("op_stop", bus.reqOperandsStop, e_stop);
            chk("mul_rdy", bus.mulOperandsReady, m_iv);
            if (m_iv) chk("mul_data", bus.mulOperandsData, m_data);
            chk("res_rdy", bus.reqResultReady, e_rdy);
            chk("mul_rstop", bus.mulResultStop, e_mrs);
            chk("inflight", inFlight, m_tq.size());
            chk("perr", protoError, m_perr);
            for (int i = 0; i < NR; i++)
                chk("res_data", bus.reqResultData[32*i +: 32],
                    bus.mulResultData);
            for (int i = 0; i < NR; i++) begin
                if (bus.reqOperandsReady[i] && !e_stop[i])
                    prod[i].push_back(fmul(bus.reqOperandsData[64*i +: 64]));
                if (e_rdy[i] && !bus.reqResultStop[i]) begin
                    if (prod[i].size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL sb_req%0d: got %h want none",
                                 i, bus.mulResultData);
                    end else begin
                        chk("sb_result", bus.reqResultData[32*i +: 32],
                            prod[i][0]);
                        void'(prod[i].pop_front());
                    end
                end
            end
            if (bus.mulResultReady && m_tq.size() == 0) m_perr = 1;
            if (m_tq.size() > 0 && bus.mulResultReady && !e_mrs)
                void'(m_tq.pop_front());
            if (m_iv && !bus.mulOperandsStop) begin
                m_tq.push_back(m_tag);
                m_iv = 0;
            end
            if (g >= 0) begin
                m_iv   = 1;
                m_data = bus.reqOperandsData[64*g +: 64];
                m_tag  = g;
                m_rr   = (g + 1) % NR;
            end
        end
    end

    // One cycle of randomized requesters plus an emulated multiplier.
    task automatic rand_cycle(input bit gen);
        logic [NR-1:0] hold;
        bit            rhold;
        #2;
        hold = bus.reqOperandsReady & bus.reqOperandsStop;
        if (bus.mulOperandsReady && !bus.mulOperandsStop)
            mq.push_back(bus.mulOperandsData);
        rhold = bus.mulResultReady && bus.mulResultStop;
        if (bus.mulResultReady && !bus.mulResultStop && mq.size() > 0)
            void'(mq.pop_front());
        tick();
        for (int i = 0; i < NR; i++) begin
            if (!hold[i]) begin
                bus.reqOperandsReady[i] = gen && ($urandom % 3 != 0);
                bus.reqOperandsData[64*i +: 64] = {$urandom, $urandom};
            end
        end
        bus.mulOperandsStop = ($urandom % 4 == 0);
        if (!rhold) begin
            if (mq.size() > 0 && $urandom % 3 != 0) begin
                bus.mulResultReady = 1'b1;
                bus.mulResultData  = fmul(mq[0]);
            end else begin
                bus.mulResultReady = 1'b0;
                bus.mulResultData  = $urandom;
            end
        end
        bus.reqResultStop = 4'($urandom);
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        tick();
        tick();
        arst_n = 1'b1;
        tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [3:0] e;
        int         c;
        arst_n               = 1'b0;
        bus.reqOperandsReady = '0;
        bus.reqOperandsData  = '0;
        bus.reqResultStop    = '0;
        bus.mulOperandsStop  = 1'b0;
        bus.mulResultReady   = 1'b0;
        bus.mulResultData    = '0;
        tick();
        bus.reqOperandsReady = 4'hF;
        #1;
        chk("reset_stop", bus.reqOperandsStop, 4'hF);
        chk("reset_mrdy", bus.mulOperandsReady, 0);
        chk("reset_infl", inFlight, 0);
        chk("reset_perr", protoError, 0);
        tick();
        bus.reqOperandsReady = '0;
        arst_n = 1'b1;
        tick();

        // Single requester: 1.5 * 2.0
        bus.reqOperandsReady = 4'b0001;
        bus.reqOperandsData[63:0] = 64'h00000080_00000060;
        #1;
        chk("single_grant", bus.reqOperandsStop, 4'b1110);
        tick();
        bus.reqOperandsReady = '0;
        chk("single_mrdy", bus.mulOperandsReady, 1);
        chk("single_mdata", bus.mulOperandsData, 64'h00000080_00000060);
        chk("single_infl0", inFlight, 0);
        tick();
        chk("single_infl1", inFlight, 1);
        bus.mulResultReady = 1'b1;
        bus.mulResultData  = 32'hC0;
        #1;
        chk("single_rrdy", bus.reqResultReady, 4'b0001);
        chk("single_rdata", bus.reqResultData[31:0], 32'hC0);
        chk("single_mrs", bus.mulResultStop, 0);
        tick();
        bus.mulResultReady = 1'b0;
        chk("single_infl2", inFlight, 0);
        do_reset();

        // Round robin into a full tag FIFO.
        for (int i = 0; i < NR; i++)
            bus.reqOperandsData[64*i +: 64] = {32'h80, 32'((i + 1) << 6)};
        bus.reqOperandsReady = 4'hF;
        for (int i = 0; i < NR; i++) begin
            e = ~(4'b0001 << i);
            #1;
            chk("rr_grant", bus.reqOperandsStop, e);
            tick();
        end
        chk("full_stop0", bus.reqOperandsStop, 4'hF);
        tick();
        chk("full_stop1", bus.reqOperandsStop, 4'hF);
        chk("full_infl", inFlight, 4);
        chk("full_mrdy", bus.mulOperandsReady, 0);
        bus.mulResultReady = 1'b1;
        bus.mulResultData  = 32'h80;
        #1;
        chk("full_rrdy", bus.reqResultReady, 4'b0001);
        chk("full_stop2", bus.reqOperandsStop, 4'hF);
        tick();
        bus.mulResultReady = 1'b0;
        chk("full_reopen", bus.reqOperandsStop, 4'b1110);
        chk("full_infl3", inFlight, 3);
        tick();
        bus.reqOperandsReady = '0;
        tick();
        chk("full_infl4", inFlight, 4);
        bus.mulResultReady = 1'b1;
        bus.mulResultData  = 32'h100;
        #1;
        chk("order_rrdy1", bus.reqResultReady, 4'b0010);
        tick();

        // Result back-pressure on head tag 2.
        bus.reqResultStop = 4'b0100;
        bus.mulResultData = 32'h180;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_mrs", bus.mulResultStop, 1);
            chk("bp_infl", inFlight, 3);
            tick();
        end
        bus.reqResultStop = '0;
        #1;
        chk("bp_release", bus.mulResultStop, 0);
        chk("bp_rrdy", bus.reqResultReady, 4'b0100);
        tick();
        chk("bp_infl2", inFlight, 2);
        bus.mulResultData = 32'h200;
        #1;
        chk("order_rrdy3", bus.reqResultReady, 4'b1000);
        tick();
        bus.mulResultData = 32'h80;
        #1;
        chk("order_rrdy0", bus.reqResultReady, 4'b0001);
        tick();
        bus.mulResultReady = 1'b0;
        #1;
        chk("order_infl", inFlight, 0);
        tick();

        // Randomized traffic against the model and scoreboard.
        mq.delete();
        for (int n = 0; n < 2500; n++) rand_cycle(1'b1);
        c = 0;
        while (c < 400 && !(mq.size() == 0 && inFlight == 0 &&
               bus.mulOperandsReady == 1'b0 && bus.reqOperandsReady == '0)) begin
            rand_cycle(1'b0);
            c++;
        end
        chk("drain_infl", inFlight, 0);
        chk("drain_mrdy", bus.mulOperandsReady, 0);
        bus.reqOperandsReady = '0;
        bus.mulResultReady   = 1'b0;
        bus.reqResultStop    = '0;
        bus.mulOperandsStop  = 1'b0;
        tick();

        // Stray result with an empty tag FIFO.
        bus.mulResultReady = 1'b1;
        bus.mulResultData  = 32'h1234;
        #1;
        chk("perr_mrs", bus.mulResultStop, 0);
        chk("perr_rrdy", bus.reqResultReady, 4'b0000);
        tick();
        bus.mulResultReady = 1'b0;
        chk("perr_set", protoError, 1);
        tick();
        tick();
        chk("perr_sticky", protoError, 1);

        // Reset with three operations in flight.
        for (int i = 1; i < NR; i++) begin
            bus.reqOperandsReady = 4'(1 << i);
            e = ~(4'b0001 << i);
            #1;
            chk("mid_grant", bus.reqOperandsStop, e);
            tick();
        end
        bus.reqOperandsReady = '0;
        tick();
        chk("mid_infl3", inFlight, 3);
        bus.reqOperandsReady = 4'hF;
        arst_n = 1'b0;
        #1;
        chk("mid_infl0", inFlight, 0);
        chk("mid_mrdy", bus.mulOperandsReady, 0);
        chk("mid_stop", bus.reqOperandsStop, 4'hF);
        chk("mid_perr", protoError, 0);
        tick();
        tick();
        arst_n = 1'b1;
        #1;
        chk("mid_rr0", bus.reqOperandsStop, 4'b1110);
        tick();
        bus.reqOperandsReady = '0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
